updown_sweep_controller: RTL and testbench

Command-driven sequencer for the up/down counter datapath. It accepts a sweep command (start value, limit, mode, repeat count) over a valid/ready handshake. It then steps its own synchronous WIDTH-bit count register up, down, or back and forth, and drives the `up` direction line. Direction and step pacing are decided here rather than by hand-toggled stimulus, and `done`/`err` pulses report completion and illegal commands to the upstream sequencer.

---
 rtl/updown_sweep_controller.sv | 162 ++++++++++++++++
 tb/tb_updown_sweep_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : updown_sweep_controller
// Description : Command-driven sweep sequencer. It accepts a sweep command
//               (start, limit, mode, repeat count) over valid/ready. It then
//               steps a WIDTH-bit count up, down or back and forth at a
//               prescaled rate, and pulses done/err toward the upstream
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_sweep_controller #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_start,
  input  logic [WIDTH-1:0] i_cmd_limit,
  input  logic [1:0]       i_cmd_mode,
  input  logic [3:0]       i_cmd_reps,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic             o_up,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  localparam logic [1:0] c_MODE_DOWN    = 2'b01;
  localparam logic [1:0] c_MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] c_MODE_ILLEGAL = 2'b11;

  // The prescaler needs at least one bit even when every cycle is a tick.
  localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
  localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);
  localparam logic [WIDTH-1:0]  c_CNT_ONE = WIDTH'(1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_limit;
  logic [1:0]       r_mode;
  logic [3:0]       r_pass;
  logic [c_PS_W-1:0] r_ps;
  logic             r_up;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_accept;
  logic             w_illegal;
  logic             w_at_target;
  logic             w_ps_wrap;
  logic [3:0]       w_reps_eff;
  logic [WIDTH-1:0] w_count_step;

  // Decode handshake, tick and next-step values from the current state.
  always_comb begin
    w_accept     = (r_state == c_ST_IDLE) && i_cmd_valid;
    w_illegal    = (i_cmd_mode == c_MODE_ILLEGAL);
    w_at_target  = (r_count == r_target);
    w_ps_wrap    = (r_ps == c_PS_LAST);
    w_reps_eff   = (i_cmd_reps == 4'd0) ? 4'd1 : i_cmd_reps;
    w_count_step = r_up ? (r_count + c_CNT_ONE) : (r_count - c_CNT_ONE);
  end

  // Sweep state machine: command intake, prescaled stepping, turnarounds.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= c_ST_IDLE;
      r_count  <= '0;
      r_target <= '0;
      r_start  <= '0;
      r_limit  <= '0;
      r_mode   <= '0;
      r_pass   <= '0;
      r_ps     <= '0;
      r_up     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_count  <= i_cmd_start;
              r_target <= i_cmd_limit;
              r_start  <= i_cmd_start;
              r_limit  <= i_cmd_limit;
              r_mode   <= i_cmd_mode;
              r_pass   <= w_reps_eff;
              r_ps     <= '0;
              r_up     <= (i_cmd_mode != c_MODE_DOWN);
              r_busy   <= 1'b1;
              r_state  <= c_ST_RUN;
            end
          end
        end
        c_ST_RUN: begin
          if (i_abort) begin
            // Abort wins over hold and over a tick on the same edge.
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!i_hold) begin
            if (!w_ps_wrap) begin
              r_ps <= r_ps + c_PS_ONE;
            end else begin
              r_ps <= '0;
              if (!w_at_target) begin
                r_count <= w_count_step;
              end else if (r_mode != c_MODE_BOUNCE) begin
                r_state <= c_ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (r_up) begin
                // Outbound leg reached the limit: turn around toward start.
                r_up     <= 1'b0;
                r_target <= r_start;
              end else if (r_pass > 4'd1) begin
                // Return leg reached start with passes left: head out again.
                r_pass   <= r_pass - 4'd1;
                r_up     <= 1'b1;
                r_target <= r_limit;
              end else begin
                r_pass  <= '0;
                r_state <= c_ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = (r_state == c_ST_IDLE);
  assign o_up        = r_up;
  assign o_count     = r_count;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_sweep_controller
// Description : Scoreboard bench for updown_sweep_controller. Each command
//               pushes its expected per-cycle outputs into a queue, which is
//               popped and compared as the sweep runs. Two instances cover
//               PRESCALE=1 and PRESCALE=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_sweep_controller;

  typedef struct packed {
    logic [3:0] cnt;
    logic       up;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_start;
  logic [3:0] cmd_limit;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_reps;
  logic       hold;
  logic       abort;
  logic       sel;

  logic       a_ready, a_up, a_busy, a_done, a_err;
  logic [3:0] a_count;
  logic       b_ready, b_up, b_busy, b_done, b_err;
  logic [3:0] b_count;

  logic       w_ready, w_up, w_busy, w_done, w_err;
  logic [3:0] w_count;

  int   n_checks;
  int   n_errors;
  exp_t q[$];
  logic [3:0] idle_cnt;
  logic       idle_up;

  updown_sweep_controller #(.WIDTH(4), .PRESCALE(1)) u_dut_p1 (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(a_ready),
    .i_cmd_start(cmd_start), .i_cmd_limit(cmd_limit), .i_cmd_mode(cmd_mode),
    .i_cmd_reps(cmd_reps), .i_hold(hold), .i_abort(abort), .o_up(a_up),
    .o_count(a_count), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
  );

  updown_sweep_controller #(.WIDTH(4), .PRESCALE(2)) u_dut_p2 (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(b_ready),
    .i_cmd_start(cmd_start), .i_cmd_limit(cmd_limit), .i_cmd_mode(cmd_mode),
    .i_cmd_reps(cmd_reps), .i_hold(hold), .i_abort(abort), .o_up(b_up),
    .o_count(b_count), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
  );

  assign w_ready = sel ? b_ready : a_ready;
  assign w_up    = sel ? b_up    : a_up;
  assign w_busy  = sel ? b_busy  : a_busy;
  assign w_done  = sel ? b_done  : a_done;
  assign w_err   = sel ? b_err   : a_err;
  assign w_count = sel ? b_count : a_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic u, input logic b,
                              input logic d, input logic e);
    exp_t r;
    r.cnt = c; r.up = u; r.busy = b; r.done = d; r.err = e;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input exp_t e);
    check_eq({tag, ".count"}, 32'(w_count), 32'(e.cnt));
    check_eq({tag, ".up"},    32'(w_up),    32'(e.up));
    check_eq({tag, ".busy"},  32'(w_busy),  32'(e.busy));
    check_eq({tag, ".done"},  32'(w_done),  32'(e.done));
    check_eq({tag, ".err"},   32'(w_err),   32'(e.err));
    check_eq({tag, ".ready"}, 32'(w_ready), 32'(!e.busy));
  endtask

  // Expected per-cycle trace of a legal sweep, derived from the step rules.
  task automatic build(input logic [3:0] s, input logic [3:0] l, input logic [1:0] m,
                       input logic [3:0] r, input int p);
    logic [3:0] c, t;
    logic       u;
    int         pass;
    q.delete();
    c = s; u = (m != 2'b01); t = l; pass = (r == 0) ? 1 : int'(r);
    for (int guard = 0; guard < 200; guard++) begin
      for (int k = 0; k < p; k++) q.push_back(mk(c, u, 1'b1, 1'b0, 1'b0));
      if (c != t) c = u ? c + 4'd1 : c - 4'd1;
      else if (m != 2'b10) break;
      else if (u) begin u = 1'b0; t = s; end
      else begin
        pass--;
        if (pass > 0) begin u = 1'b1; t = l; end
        else break;
      end
    end
    q.push_back(mk(c, u, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(c, u, 1'b0, 1'b0, 1'b0));
  endtask

  // Observation n is taken after the (n-1)th edge past acceptance; the
  // *_at arguments name the observation first affected by that input.
  task automatic run(input string tag, input logic [3:0] s, input logic [3:0] l,
                     input logic [1:0] m, input logic [3:0] r, input int p,
                     input int hold_at, input int hold_len,
                     input int abort_at, input int reset_at);
    exp_t e;
    int   n;
    build(s, l, m, r, p);
    if (hold_at > 1)
      for (int k = 0; k < hold_len; k++) q.insert(hold_at - 1, q[hold_at - 2]);
    if (abort_at > 1) begin
      e = q[abort_at - 2];
      while (q.size() > abort_at - 1) void'(q.pop_back());
      e.busy = 1'b0; e.done = 1'b0;
      for (int k = 0; k < 3; k++) q.push_back(e);
    end
    if (reset_at > 1) begin
      while (q.size() > reset_at - 1) void'(q.pop_back());
      for (int k = 0; k < 3; k++) q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    check_eq({tag, ".ready_pre"}, 32'(w_ready), 32'd1);
    cmd_start = s; cmd_limit = l; cmd_mode = m; cmd_reps = r; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    n = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      compare($sformatf("%s@%0d", tag, n), e);
      idle_cnt = e.cnt; idle_up = e.up;
      hold  = (hold_at > 0 && n + 1 >= hold_at && n + 1 < hold_at + hold_len) ||
              (abort_at == n + 1);
      abort = (abort_at == n + 1);
      reset = (reset_at == n + 1);
      cycle();
      n++;
    end
    hold = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic illegal_cmd();
    cmd_mode = 2'b11; cmd_start = 4'd9; cmd_limit = 4'd1; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    compare("illegal@1", mk(idle_cnt, idle_up, 1'b0, 1'b0, 1'b1));
    cycle();
    compare("illegal@2", mk(idle_cnt, idle_up, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; sel = 1'b0;
    hold = 1'b0; abort = 1'b0;
    cmd_start = 4'd9; cmd_limit = 4'd12; cmd_mode = 2'b00; cmd_reps = 4'd0;
    reset = 1'b1; cmd_valid = 1'b1;
    cycle();
    cycle();
    compare("reset", mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    reset = 1'b0; cmd_valid = 1'b0;
    cycle();
    compare("post_reset", mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle_cnt = 4'd0; idle_up = 1'b1;

    run("up_2_5",        4'd2, 4'd5,  2'b00, 4'd0, 1, 0, 0, 0, 0);
    run("down_wrap",     4'd1, 4'd14, 2'b01, 4'd0, 1, 0, 0, 0, 0);
    run("down_eq",       4'd7, 4'd7,  2'b01, 4'd0, 1, 0, 0, 0, 0);
    run("up_wrap",       4'd14, 4'd1, 2'b00, 4'd0, 1, 0, 0, 0, 0);
    run("bounce_r2",     4'd3, 4'd5,  2'b10, 4'd2, 1, 0, 0, 0, 0);
    run("bounce_r0",     4'd3, 4'd5,  2'b10, 4'd0, 1, 0, 0, 0, 0);
    run("bounce_eq",     4'd6, 4'd6,  2'b10, 4'd1, 1, 0, 0, 0, 0);
    illegal_cmd();
    run("reset_mid",     4'd3, 4'd5,  2'b10, 4'd2, 1, 0, 0, 0, 6);

    // Bring both instances to a known idle state before switching over.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sel = 1'b1;
    idle_cnt = 4'd0; idle_up = 1'b1;
    cycle();
    compare("p2_idle", mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));

    run("p2_plain",      4'd2, 4'd4,  2'b00, 4'd0, 2, 0, 0, 0, 0);
    run("p2_hold",       4'd2, 4'd6,  2'b00, 4'd0, 2, 3, 3, 0, 0);
    run("p2_abort",      4'd10, 4'd2, 2'b00, 4'd0, 2, 0, 0, 5, 0);
    illegal_cmd();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
